// File: rtl/lbp_pkg.sv
// Shared constants, state encoding and helpers for the LBP histogram stage.
package lbp_pkg;

    localparam int unsigned IMG_W    = 128;
    localparam int unsigned IMG_H    = 128;
    localparam int unsigned CODE_W   = 8;
    localparam int unsigned CNT_W    = 14;
    localparam int unsigned ADDR_W   = 14;
    localparam int unsigned NUM_BINS = 1 << CODE_W;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // True for addresses on the outer ring of the frame (first/last row or column).
    function automatic logic is_border(input logic [ADDR_W-1:0] addr);
        return (addr[6:0] == 7'd0) || (addr[6:0] == 7'(IMG_W - 1)) ||
               (addr < ADDR_W'(IMG_W)) || (addr >= ADDR_W'(IMG_W * (IMG_H - 1)));
    endfunction

endpackage

// File: rtl/lbp_hist_bank.sv
// Histogram bin register file: one write port (saturating increment or clear), one async read port.
module lbp_hist_bank
    import lbp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic              wr_clr_i,
    input  logic [CODE_W-1:0] wr_idx_i,
    input  logic [CODE_W-1:0] rd_idx_i,
    output logic [CNT_W-1:0]  rd_data_o
);

    logic [CNT_W-1:0] bins_q [NUM_BINS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bins_q <= '{default: '0};
        end else if (wr_en_i) begin
            bins_q[wr_idx_i] <= wr_clr_i ? '0 : sat_inc(bins_q[wr_idx_i]);
        end
    end

    assign rd_data_o = bins_q[rd_idx_i];

endmodule

// File: rtl/lbp_hist.sv
// Accumulates a 256-bin histogram of LBP codes per frame and streams it out (clear-on-read)
// over a valid/ready port when the LBP engine signals frame completion.
module lbp_hist
    import lbp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lbp_valid_i,
    input  logic [ADDR_W-1:0] lbp_addr_i,
    input  logic [CODE_W-1:0] lbp_data_i,
    input  logic              finish_i,
    output logic              hist_valid_o,
    input  logic              hist_ready_i,
    output logic [CODE_W-1:0] hist_bin_o,
    output logic [CNT_W-1:0]  hist_count_o,
    output logic              hist_done_o,
    output logic [CNT_W-1:0]  pix_count_o,
    output logic              err_o
);

    state_t            state_q, state_d;
    logic              finish_q;
    logic              s1_v_q, s1_v_d;
    logic [CODE_W-1:0] s1_code_q, s1_code_d;
    logic [CNT_W-1:0]  pix_q, pix_d;
    logic              err_q, err_d;
    logic              hist_valid_q, hist_valid_d;
    logic [CODE_W-1:0] hist_bin_q, hist_bin_d;
    logic [CNT_W-1:0]  hist_count_q, hist_count_d;
    logic              hist_done_q, hist_done_d;

    logic              wr_en, wr_clr;
    logic [CODE_W-1:0] wr_idx;
    logic [CNT_W-1:0]  rd_data;
    logic              hs, hs_last;

    assign hs      = hist_valid_q && hist_ready_i;
    assign hs_last = hs && (hist_bin_q == CODE_W'(NUM_BINS - 1));

    lbp_hist_bank u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_clr_i  (wr_clr),
        .wr_idx_i  (wr_idx),
        .rd_idx_i  (hist_bin_d),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (finish_i && !finish_q) state_d = FLUSH;
            FLUSH:   state_d = DUMP;
            DUMP:    if (hs_last) state_d = DONE;
            DONE:    state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Datapath next-state; the pending s1 update always owns the bank write port, and
    // hist_valid only rises once s1 has drained, so the two never collide.
    always_comb begin
        s1_v_d       = lbp_valid_i && ((state_q == ACCUM) || (state_q == FLUSH));
        s1_code_d    = lbp_data_i;
        pix_d        = s1_v_q ? sat_inc(pix_q) : pix_q;
        err_d        = err_q;
        hist_valid_d = 1'b0;
        hist_bin_d   = hist_bin_q;
        hist_count_d = hist_count_q;
        hist_done_d  = 1'b0;
        wr_en        = s1_v_q || hs;
        wr_clr       = !s1_v_q;
        wr_idx       = s1_v_q ? s1_code_q : hist_bin_q;

        if (lbp_valid_i && (is_border(lbp_addr_i) || (state_q == DUMP) || (state_q == DONE))) begin
            err_d = 1'b1;
        end

        case (state_q)
            FLUSH: begin
                hist_bin_d   = '0;
                hist_count_d = '0;
            end
            DUMP: begin
                hist_valid_d = !hs_last;
                hist_done_d  = hs_last;
                if (hs) hist_bin_d = hist_bin_q + CODE_W'(1);
                hist_count_d = (s1_v_q && (s1_code_q == hist_bin_d)) ? sat_inc(rd_data) : rd_data;
                if (hs_last) hist_count_d = '0;
            end
            DONE: begin
                pix_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finish_q     <= 1'b0;
            s1_v_q       <= 1'b0;
            s1_code_q    <= '0;
            pix_q        <= '0;
            err_q        <= 1'b0;
            hist_valid_q <= 1'b0;
            hist_bin_q   <= '0;
            hist_count_q <= '0;
            hist_done_q  <= 1'b0;
        end else begin
            finish_q     <= finish_i;
            s1_v_q       <= s1_v_d;
            s1_code_q    <= s1_code_d;
            pix_q        <= pix_d;
            err_q        <= err_d;
            hist_valid_q <= hist_valid_d;
            hist_bin_q   <= hist_bin_d;
            hist_count_q <= hist_count_d;
            hist_done_q  <= hist_done_d;
        end
    end

    assign hist_valid_o = hist_valid_q;
    assign hist_bin_o   = hist_bin_q;
    assign hist_count_o = hist_count_q;
    assign hist_done_o  = hist_done_q;
    assign pix_count_o  = pix_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Directed + randomized bench for lbp_hist against a frame-level histogram model.
module tb_lbp_hist;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lbp_valid_i;
    logic [13:0] lbp_addr_i;
    logic [7:0]  lbp_data_i;
    logic        finish_i;
    logic        hist_valid_o;
    logic        hist_ready_i;
    logic [7:0]  hist_bin_o;
    logic [13:0] hist_count_o;
    logic        hist_done_o;
    logic [13:0] pix_count_o;
    logic        err_o;

    int   tests = 0;
    int   fails = 0;
    int   mbins [256];
    int   mpix;
    logic merr;

    localparam int SAT = 16383;

    lbp_hist dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lbp_valid_i  (lbp_valid_i),
        .lbp_addr_i   (lbp_addr_i),
        .lbp_data_i   (lbp_data_i),
        .finish_i     (finish_i),
        .hist_valid_o (hist_valid_o),
        .hist_ready_i (hist_ready_i),
        .hist_bin_o   (hist_bin_o),
        .hist_count_o (hist_count_o),
        .hist_done_o  (hist_done_o),
        .pix_count_o  (pix_count_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_clear();
        foreach (mbins[i]) mbins[i] = 0;
        mpix = 0;
        merr = 1'b0;
    endtask

    function automatic logic [13:0] int_addr();
        int row = $urandom_range(1, 126);
        int col = $urandom_range(1, 126);
        return 14'(row * 128 + col);
    endfunction

    // Drive one code for one cycle and account for it in the model.
    task automatic send(input logic [7:0] code, input logic [13:0] addr);
        int row = int'(addr) / 128;
        int col = int'(addr) % 128;
        lbp_valid_i = 1'b1;
        lbp_data_i  = code;
        lbp_addr_i  = addr;
        if (row == 0 || row == 127 || col == 0 || col == 127) merr = 1'b1;
        if (mbins[code] < SAT) mbins[code]++;
        if (mpix < SAT) mpix++;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        lbp_valid_i = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Stream out the histogram; mode 0 always-ready, 1 pattern 1,0,0,1, 2 random.
    task automatic run_dump(input int mode, input int stop_at, input bit inject);
        int   eb = 0, cyc = 0, k = 0;
        bit   injected = 0;
        logic rdy, held = 1'b0;
        logic [31:0] pb = 0, pc = 0;
        while (eb < stop_at && cyc < 3000) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 4 == 0) || (k % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            hist_ready_i = rdy;
            lbp_valid_i  = 1'b0;
            if (inject && !injected && eb == 50 && hist_valid_o) begin
                lbp_valid_i = 1'b1;
                lbp_data_i  = 8'($urandom_range(0, 255));
                lbp_addr_i  = int_addr();
                merr        = 1'b1;
                injected    = 1;
            end
            check("done_low_in_dump", hist_done_o, 0);
            if (hist_valid_o) begin
                if (held) begin
                    check("hold_bin", hist_bin_o, pb);
                    check("hold_cnt", hist_count_o, pc);
                end
                check("bin_order", hist_bin_o, eb);
                check("bin_count", hist_count_o, mbins[eb]);
                held = !rdy;
                pb   = hist_bin_o;
                pc   = hist_count_o;
                k++;
                if (rdy) begin mbins[eb] = 0; eb++; end
            end
            @(posedge clk); #1;
            cyc++;
        end
        hist_ready_i = 1'b0;
        lbp_valid_i  = 1'b0;
        if (cyc >= 3000) begin
            tests++;
            fails++;
            $error("FAIL dump_timeout: observed %0d bins expected %0d", eb, stop_at);
        end
        if (stop_at < 256) return;
        check("valid_drop", hist_valid_o, 0);
        check("done_pulse", hist_done_o, 1);
        check("pix_count", pix_count_o, mpix);
        check("err", err_o, merr);
        @(posedge clk); #1;
        check("done_one_cycle", hist_done_o, 0);
        check("pix_cleared", pix_count_o, 0);
        mpix = 0;
    endtask

    // Finish rises with one code in the ACCUM cycle and one in FLUSH; both must be counted.
    task automatic end_frame(input int mode, input logic [7:0] c0, input logic [7:0] c1);
        finish_i = 1'b1;
        send(c0, int_addr());
        send(c1, int_addr());
        lbp_valid_i = 1'b0;
        run_dump(mode, 256, 0);
    endtask

    task automatic random_frame(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) != 0) send(8'($urandom_range(0, 255)), int_addr());
            else idle(1);
        end
        lbp_valid_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        lbp_valid_i = 1'b0; lbp_addr_i = '0; lbp_data_i = '0;
        finish_i = 1'b0; hist_ready_i = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", hist_valid_o, 0);
        check("rst_bin", hist_bin_o, 0);
        check("rst_count", hist_count_o, 0);
        check("rst_done", hist_done_o, 0);
        check("rst_pix", pix_count_o, 0);
        check("rst_err", err_o, 0);
        rst_n = 1'b1;
        idle(2);

        // Full frame of code 0 at every interior pixel.
        for (int r = 1; r <= 126; r++)
            for (int c = 1; c <= 126; c++)
                send(8'h00, 14'(r * 128 + c));
        lbp_valid_i = 1'b0;
        finish_i = 1'b1;
        idle(1);
        run_dump(0, 256, 0);
        check("frame1_err", err_o, 0);
        finish_i = 1'b0;
        idle(2);

        // Back-to-back identical codes, then stalled readout.
        send(8'h05, int_addr());
        send(8'h05, int_addr());
        send(8'h05, int_addr());
        send(8'hFF, int_addr());
        lbp_valid_i = 1'b0;
        finish_i = 1'b1;
        idle(1);
        run_dump(1, 256, 0);
        // finish still high: no new dump may start
        for (int i = 0; i < 5; i++) begin
            check("no_retrigger", hist_valid_o, 0);
            idle(1);
        end
        finish_i = 1'b0;
        idle(1);

        // Second frame shows clear-on-read; then random frames with codes in the finish/FLUSH cycles.
        for (int i = 0; i < 10; i++) send(8'h12, int_addr());
        lbp_valid_i = 1'b0;
        finish_i = 1'b1;
        idle(1);
        run_dump(2, 256, 0);
        finish_i = 1'b0;
        idle(1);
        random_frame(400);
        end_frame(2, 8'($urandom_range(0, 255)), 8'h00);
        finish_i = 1'b0;
        idle(1);
        random_frame(300);
        end_frame(0, 8'h00, 8'($urandom_range(0, 255)));
        finish_i = 1'b0;
        idle(1);

        // Code during DUMP is dropped and flags err.
        random_frame(200);
        finish_i = 1'b1;
        idle(1);
        run_dump(2, 256, 1);
        finish_i = 1'b0;

        // Border addresses flag err but are still counted.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_clear();
        idle(1);
        check("err_after_reset", err_o, 0);
        send(8'h33, 14'd0);
        idle(2);
        check("border_err", err_o, 1);
        send(8'h34, 14'd127);
        send(8'h34, 14'd16256);
        send(8'h35, 14'(5 * 128 + 127));
        random_frame(50);
        finish_i = 1'b1;
        idle(1);
        run_dump(2, 256, 0);
        finish_i = 1'b0;

        // Reset in the middle of a dump.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_clear();
        idle(1);
        random_frame(300);
        finish_i = 1'b1;
        idle(1);
        run_dump(0, 100, 0);
        check("pre_rst_bin", hist_bin_o, 100);
        rst_n = 1'b0;
        finish_i = 1'b0;
        #1;
        check("midrst_valid", hist_valid_o, 0);
        check("midrst_bin", hist_bin_o, 0);
        check("midrst_count", hist_count_o, 0);
        check("midrst_pix", pix_count_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        idle(2);
        finish_i = 1'b1;
        idle(1);
        run_dump(0, 256, 0);
        finish_i = 1'b0;
        idle(1);

        // Saturation of a bin and of pix_count.
        for (int i = 0; i < SAT + 3; i++) send(8'h07, int_addr());
        lbp_valid_i = 1'b0;
        check("sat_model", mbins[7], SAT);
        finish_i = 1'b1;
        idle(1);
        run_dump(0, 256, 0);
        finish_i = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
